// File: rtl/cube_move_pkg.sv
// Shared move-code definitions for the cube solver motor stage: move encoding,
// face indices, decode helpers and the executor state type.
package cube_move_pkg;

  typedef enum logic [3:0] {
    MV_U_CW  = 4'd0,  MV_D_CW  = 4'd1,  MV_L_CW  = 4'd2,
    MV_R_CW  = 4'd3,  MV_F_CW  = 4'd4,  MV_B_CW  = 4'd5,
    MV_U_CCW = 4'd6,  MV_D_CCW = 4'd7,  MV_L_CCW = 4'd8,
    MV_R_CCW = 4'd9,  MV_F_CCW = 4'd10, MV_B_CCW = 4'd11
  } move_e;

  localparam int NUM_FACES = 6;

  localparam logic [2:0] FACE_U = 3'd0;
  localparam logic [2:0] FACE_D = 3'd1;
  localparam logic [2:0] FACE_L = 3'd2;
  localparam logic [2:0] FACE_R = 3'd3;
  localparam logic [2:0] FACE_F = 3'd4;
  localparam logic [2:0] FACE_B = 3'd5;

  // The step/dir phasing (STEP_HI/STEP_LO) lives inside step_pulse_gen.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STEP   = 2'd2,
    ST_SETTLE = 2'd3
  } exec_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_valid_move(input logic [3:0] code);
    return code <= MV_B_CCW;
  endfunction

  function automatic logic [2:0] move_face(input logic [3:0] code);
    logic [3:0] w_face;
    w_face = (code >= 4'(NUM_FACES)) ? code - 4'(NUM_FACES) : code;
    return w_face[2:0];
  endfunction

  function automatic logic move_dir(input logic [3:0] code);
    return code < MV_U_CCW;
  endfunction

  function automatic logic [5:0] face_onehot(input logic [2:0] face);
    logic [5:0] w_oh;
    case (face)
      FACE_U:  w_oh = 6'b000001;
      FACE_D:  w_oh = 6'b000010;
      FACE_L:  w_oh = 6'b000100;
      FACE_R:  w_oh = 6'b001000;
      FACE_F:  w_oh = 6'b010000;
      FACE_B:  w_oh = 6'b100000;
      default: w_oh = 6'b000000;
    endcase
    return w_oh;
  endfunction

endpackage

// File: rtl/stepper_move_executor_step_pulse_gen.sv
// Generates STEPS_QTR step pulses of STEP_PERIOD cycles (STEP_HIGH high) after
// a start strobe; o_last flags the final cycle of the final period.
module step_pulse_gen
  import cube_move_pkg::*;
#(
  parameter int STEP_PERIOD = 20,
  parameter int STEP_HIGH   = 10,
  parameter int STEPS_QTR   = 50
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_abort,
  output logic o_step,
  output logic o_last
);

  localparam int CW = $clog2(max2(max2(STEP_PERIOD, STEP_HIGH), STEPS_QTR)) + 1;
  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] PHASE_LAST = CW'(STEP_PERIOD - 1);
  localparam logic [CW-1:0] STEP_LAST  = CW'(STEPS_QTR - 1);
  localparam logic [CW-1:0] HIGH_LEN   = CW'(STEP_HIGH);

  logic          r_active;
  logic          r_step;
  logic [CW-1:0] r_phase;
  logic [CW-1:0] r_count;
  logic          w_period_end;

  assign w_period_end = r_active && (r_phase == PHASE_LAST);
  assign o_last       = w_period_end && (r_count == STEP_LAST);
  assign o_step       = r_step;

  // NOTE: non-blocking assignments in clocked blocks so every register sees pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_step   <= 1'b0;
      r_phase  <= '0;
      r_count  <= '0;
    end else if (i_abort) begin
      r_active <= 1'b0;
      r_step   <= 1'b0;
      r_phase  <= '0;
      r_count  <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_step   <= 1'b1;
      r_phase  <= '0;
      r_count  <= '0;
    end else if (r_active) begin
      if (w_period_end) begin
        r_phase <= '0;
        if (o_last) begin
          r_active <= 1'b0;
          r_step   <= 1'b0;
        end else begin
          r_count <= r_count + ONE;
          r_step  <= 1'b1;
        end
      end else begin
        r_phase <= r_phase + ONE;
        r_step  <= (r_phase + ONE) < HIGH_LEN;
      end
    end
  end

endmodule

// File: rtl/stepper_move_executor.sv
// Executes one cube move per handshake: enables one face motor, sets direction,
// emits one quarter turn of step pulses, then settles and drops the enable.
module stepper_move_executor
  import cube_move_pkg::*;
#(
  parameter int   STEPS_QTR   = 50,
  parameter int   STEP_PERIOD = 20,
  parameter int   STEP_HIGH   = 10,
  parameter int   EN_SETUP    = 20,
  parameter int   SETTLE      = 200,
  parameter logic MS_LEVEL    = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_move,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_abort,
  output logic [5:0] o_en,
  output logic       o_step,
  output logic       o_dir,
  output logic       o_ms,
  output logic       o_done,
  output logic       o_err,
  output logic [3:0] o_cur_move
);

  localparam int CW = $clog2(max2(max2(max2(STEPS_QTR, STEP_PERIOD),
                                       max2(STEP_HIGH, EN_SETUP)), SETTLE)) + 1;
  localparam logic [CW-1:0] ONE         = CW'(1);
  localparam logic [CW-1:0] SETUP_LAST  = CW'(EN_SETUP - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  exec_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [5:0]    r_en;
  logic          r_dir;
  logic          r_done;
  logic          r_err;
  logic [3:0]    r_cur_move;

  logic w_abort;
  logic w_xfer;
  logic w_start;
  logic w_last;

  assign o_ready    = (r_state == ST_IDLE);
  // Abort wins over a same-cycle handshake, even from IDLE.
  assign w_xfer     = i_valid && o_ready && !i_abort;
  assign w_abort    = i_abort && (r_state != ST_IDLE);
  assign w_start    = (r_state == ST_SETUP) && (r_cnt == SETUP_LAST);

  assign o_en       = r_en;
  assign o_dir      = r_dir;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_cur_move = r_cur_move;
  assign o_ms       = MS_LEVEL;

  step_pulse_gen #(
    .STEP_PERIOD (STEP_PERIOD),
    .STEP_HIGH   (STEP_HIGH),
    .STEPS_QTR   (STEPS_QTR)
  ) u_pulse (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (w_start),
    .i_abort (w_abort),
    .o_step  (o_step),
    .o_last  (w_last)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_en       <= '0;
      r_dir      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cur_move <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_abort) begin
        r_state <= ST_IDLE;
        r_en    <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_xfer) begin
              r_cur_move <= i_move;
              if (is_valid_move(i_move)) begin
                r_en    <= face_onehot(move_face(i_move));
                r_dir   <= move_dir(i_move);
                r_cnt   <= '0;
                r_state <= ST_SETUP;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          ST_SETUP: begin
            if (w_start) begin
              r_cnt   <= '0;
              r_state <= ST_STEP;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          end
          ST_STEP: begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (r_cnt == SETTLE_LAST) begin
              r_cnt   <= '0;
              r_en    <= '0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_en    <= '0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stepper_move_executor.sv
// Self-checking bench: directed move table, hand-written corner sequences and
// random traffic against a schedule-based reference model.
module tb_stepper_move_executor;

  localparam int P_STEPS  = 4;
  localparam int P_PER    = 4;
  localparam int P_HI     = 2;
  localparam int P_SETUP  = 3;
  localparam int P_SETTLE = 5;

  // Cycle offsets from the transfer cycle, derived from the move timing rules.
  localparam int T_STEP0    = 1 + P_SETUP;
  localparam int T_STEP_END = T_STEP0 + P_STEPS * P_PER;
  localparam int T_DONE     = T_STEP_END + P_SETTLE;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_move;
  logic       i_valid;
  logic       i_abort;
  logic       o_ready;
  logic [5:0] o_en;
  logic       o_step;
  logic       o_dir;
  logic       o_ms;
  logic       o_done;
  logic       o_err;
  logic [3:0] o_cur_move;

  stepper_move_executor #(
    .STEPS_QTR   (P_STEPS),
    .STEP_PERIOD (P_PER),
    .STEP_HIGH   (P_HI),
    .EN_SETUP    (P_SETUP),
    .SETTLE      (P_SETTLE),
    .MS_LEVEL    (1'b0)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_move     (i_move),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_abort    (i_abort),
    .o_en       (o_en),
    .o_step     (o_step),
    .o_dir      (o_dir),
    .o_ms       (o_ms),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_cur_move (o_cur_move)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: one outstanding move described by its start cycle.
  logic       m_busy;
  int         m_t0;
  logic [5:0] m_en;
  logic       m_dir;
  logic [3:0] m_cur;

  int   pulse_cnt;
  logic prev_step;
  logic done_seen;

  typedef struct {
    logic [3:0] code;
    logic [5:0] exp_en;
    logic       exp_dir;
    logic       exp_err;
    int         exp_pulses;
  } move_vec_t;

  move_vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_t0      = 0;
    m_en      = '0;
    m_dir     = 1'b0;
    m_cur     = '0;
    prev_step = 1'b0;
  endtask

  // Present inputs for the current cycle, clock once, and compare every output.
  task automatic cycle(input logic v, input logic [3:0] mv, input logic ab);
    int         rel;
    logic       idle_now;
    logic       xfer;
    logic [5:0] e_en;
    logic       e_step;
    logic       e_done;
    logic       e_err;
    logic       e_ready;
    i_valid  = v;
    i_move   = mv;
    i_abort  = ab;
    idle_now = !m_busy || (cyc - m_t0) >= T_DONE;
    xfer     = v && idle_now && !ab;
    if (idle_now || ab) m_busy = 1'b0;
    e_err = xfer && (mv >= 4'd12);
    if (xfer) begin
      m_cur = mv;
      if (mv < 4'd12) begin
        m_busy = 1'b1;
        m_t0   = cyc;
        m_en   = 6'b000001 << (int'(mv) % 6);
        m_dir  = (mv < 4'd6);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    rel     = cyc - m_t0;
    e_en    = (m_busy && rel >= 1 && rel < T_DONE) ? m_en : 6'b0;
    e_step  = m_busy && rel >= T_STEP0 && rel < T_STEP_END && ((rel - T_STEP0) % P_PER) < P_HI;
    e_done  = m_busy && rel == T_DONE;
    e_ready = !m_busy || rel >= T_DONE;
    check("en", 32'(o_en), 32'(e_en));
    check("step", 32'(o_step), 32'(e_step));
    check("done", 32'(o_done), 32'(e_done));
    check("err", 32'(o_err), 32'(e_err));
    check("ready", 32'(o_ready), 32'(e_ready));
    check("cur_move", 32'(o_cur_move), 32'(m_cur));
    check("en_onehot", 32'($countones(o_en) <= 1), 32'd1);
    if (e_en != 6'b0) check("dir", 32'(o_dir), 32'(m_dir));
    if (o_step && !prev_step) pulse_cnt++;
    if (o_done) done_seen = 1'b1;
    prev_step = o_step;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  en_seen;
    logic        dir_seen;
    logic        err_seen;
    logic [31:0] mask;
    logic        done25;
    logic        ready25;

    vecs[0] = '{4'd3,  6'b001000, 1'b1, 1'b0, 4};
    vecs[1] = '{4'd7,  6'b000010, 1'b0, 1'b0, 4};
    vecs[2] = '{4'd13, 6'b000000, 1'b0, 1'b1, 0};
    vecs[3] = '{4'd11, 6'b100000, 1'b0, 1'b0, 4};
    vecs[4] = '{4'd0,  6'b000001, 1'b1, 1'b0, 4};
    vecs[5] = '{4'd15, 6'b000000, 1'b0, 1'b1, 0};

    rst = 1'b1; i_valid = 1'b0; i_move = '0; i_abort = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("rst_en", 32'(o_en), 32'd0);
    check("rst_step", 32'(o_step), 32'd0);
    check("rst_dir", 32'(o_dir), 32'd0);
    check("rst_done_err", 32'({o_done, o_err}), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_cur", 32'(o_cur_move), 32'd0);
    check("rst_ms", 32'(o_ms), 32'd0);
    rst = 1'b0;

    // Table of single moves, each run to completion.
    for (int i = 0; i < 6; i++) begin
      pulse_cnt = 0; en_seen = '0; dir_seen = 1'b0; err_seen = 1'b0;
      cycle(1'b1, vecs[i].code, 1'b0);
      for (int k = 0; k < 30; k++) begin
        en_seen |= o_en;
        if (o_en != 6'b0) dir_seen = o_dir;
        if (o_err) err_seen = 1'b1;
        cycle(1'b0, 4'd0, 1'b0);
      end
      check($sformatf("vec%0d_en", i), 32'(en_seen), 32'(vecs[i].exp_en));
      if (vecs[i].exp_en != 6'b0) check($sformatf("vec%0d_dir", i), 32'(dir_seen), 32'(vecs[i].exp_dir));
      check($sformatf("vec%0d_err", i), 32'(err_seen), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_pulses", i), 32'(pulse_cnt), 32'(vecs[i].exp_pulses));
      check($sformatf("vec%0d_cur", i), 32'(o_cur_move), 32'(vecs[i].code));
    end

    // R CW: exact step timing and done cycle.
    mask = '0;
    cycle(1'b1, 4'd3, 1'b0);
    check("rcw_en_c1", 32'(o_en), 32'h08);
    check("rcw_dir_c1", 32'(o_dir), 32'd1);
    if (o_step) mask[1] = 1'b1;
    for (int k = 2; k <= 25; k++) begin
      cycle(1'b0, 4'd0, 1'b0);
      if (o_step) mask[k] = 1'b1;
    end
    check("rcw_done_c25", 32'(o_done), 32'd1);
    check("rcw_en_c25", 32'(o_en), 32'd0);
    check("rcw_ready_c25", 32'(o_ready), 32'd1);
    check("rcw_step_mask", mask, 32'h0003_3330);
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'd0, 1'b0);

    // Abort during the second step pulse.
    pulse_cnt = 0; done_seen = 1'b0;
    cycle(1'b1, 4'd0, 1'b0);
    for (int k = 1; k <= 8; k++) cycle(1'b0, 4'd0, 1'b0);
    cycle(1'b0, 4'd0, 1'b1);
    check("abort_en", 32'(o_en), 32'd0);
    check("abort_step", 32'(o_step), 32'd0);
    check("abort_ready", 32'(o_ready), 32'd1);
    for (int k = 0; k < 30; k++) cycle(1'b0, 4'd0, 1'b0);
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_pulses", 32'(pulse_cnt), 32'd2);

    // Back-to-back: valid held, second move accepted in the done cycle.
    done25 = 1'b0; ready25 = 1'b0;
    cycle(1'b1, 4'd4, 1'b0);
    for (int j = 1; j <= 25; j++) begin
      if (j == 25) begin
        done25  = o_done;
        ready25 = o_ready;
      end
      cycle(1'b1, 4'd10, 1'b0);
    end
    check("b2b_done25", 32'(done25), 32'd1);
    check("b2b_ready25", 32'(ready25), 32'd1);
    check("b2b_en26", 32'(o_en), 32'h10);
    check("b2b_dir26", 32'(o_dir), 32'd0);
    check("b2b_cur26", 32'(o_cur_move), 32'd10);
    for (int k = 0; k < 30; k++) cycle(1'b0, 4'd0, 1'b0);

    // Asynchronous reset mid-move.
    cycle(1'b1, 4'd2, 1'b0);
    for (int k = 1; k <= 9; k++) cycle(1'b0, 4'd0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("arst_en", 32'(o_en), 32'd0);
    check("arst_step", 32'(o_step), 32'd0);
    check("arst_ready", 32'(o_ready), 32'd1);
    check("arst_cur", 32'(o_cur_move), 32'd0);
    @(posedge clk); #1;
    check("arst_en_edge", 32'(o_en), 32'd0);
    check("arst_ready_edge", 32'(o_ready), 32'd1);
    rst = 1'b0;
    model_reset();

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      cycle(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0));
    end
    for (int k = 0; k < 30; k++) cycle(1'b0, 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
